// File: rtl/g15_io_pkg.sv
// Shared types for the G-15 I/O emulation blocks.
// Contents:
//   photo_frame_t  - one 5-bit tape frame (bit 0 = channel 1)
//   reader_state_t - photo reader sequencing states
//   tape_dir_t     - decoded tape drive direction
//   decode_dir     - maps the FWD/REV drive pair onto tape_dir_t
package g15_io_pkg;

    typedef logic [4:0] photo_frame_t;

    typedef enum logic [1:0] {
        RDR_IDLE = 2'd0,
        RDR_HOLE = 2'd1,
        RDR_GAP  = 2'd2
    } reader_state_t;

    typedef enum logic [1:0] {
        DIR_STOP = 2'd0,
        DIR_FWD  = 2'd1,
        DIR_REV  = 2'd2
    } tape_dir_t;

    // Both drives asserted is treated the same as neither: the tape stops.
    function automatic tape_dir_t decode_dir(input logic fwd, input logic rev);
        tape_dir_t d;
        case ({fwd, rev})
            2'b10:   d = DIR_FWD;
            2'b01:   d = DIR_REV;
            default: d = DIR_STOP;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tape_frame_ram.sv
// Single-port tape image store, DEPTH x 5 bits.
// Ports:
//   clk   - clock
//   we    - write enable (write has priority over read)
//   re    - read enable; rdata updates one cycle later and holds otherwise
//   addr  - frame address
//   wdata - frame to write
//   rdata - registered read data
module tape_frame_ram
    import g15_io_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  photo_frame_t      wdata,
    output photo_frame_t      rdata
);

    photo_frame_t mem_r [DEPTH];
    photo_frame_t rdata_r;

    // Synchronous write or read; read data is held between reads.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/phototape_reader_emu.sv
// G-15 photoelectric tape reader emulator.
// Holds a host-loaded image of 5-bit frames and plays it under a virtual
// read head, driven by io_top's forward/reverse commands. Each frame period
// shows the holes for HOLE_CYCLES cycles and then a blank gap.
// Ports:
//   CLOCK, rst (sync, active-low)
//   PHOTO_TAPE_FWD / PHOTO_TAPE_REV - drive commands from io_top
//   PHOTO1..PHOTO5                  - hole sense, PHOTO1 = frame bit 0
//   load_valid/load_data/load_ready - host frame append interface
//   load_clear, rewind              - host controls, honoured only when idle
//   tape_len, head_pos              - frames loaded, current head index
//   at_end, at_start, moving        - head/motion status
module phototape_reader_emu
    import g15_io_pkg::*;
#(
    parameter int TAPE_DEPTH   = 4096,
    parameter int FRAME_CYCLES = 2000,
    parameter int HOLE_CYCLES  = 800
) (
    input  logic                          CLOCK,
    input  logic                          rst,
    input  logic                          PHOTO_TAPE_FWD,
    input  logic                          PHOTO_TAPE_REV,
    output logic                          PHOTO1,
    output logic                          PHOTO2,
    output logic                          PHOTO3,
    output logic                          PHOTO4,
    output logic                          PHOTO5,
    input  logic                          load_valid,
    input  logic [4:0]                    load_data,
    output logic                          load_ready,
    input  logic                          load_clear,
    input  logic                          rewind,
    output logic [$clog2(TAPE_DEPTH):0]   tape_len,
    output logic [$clog2(TAPE_DEPTH):0]   head_pos,
    output logic                          at_end,
    output logic                          at_start,
    output logic                          moving
);

    localparam int AW = $clog2(TAPE_DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = $clog2(FRAME_CYCLES);

    reader_state_t state_r, state_nxt;
    tape_dir_t     dir_r, dir_nxt, dir_s;
    logic [PW-1:0] phase_r, phase_nxt;
    logic [LW-1:0] head_r, head_nxt, len_r, len_nxt;
    logic [LW-1:0] head_inc_s, head_dec_s;
    photo_frame_t  photo_r, ram_rdata_s;
    logic          load_ready_r, at_end_r, at_start_r, moving_r;
    logic          ram_we_s, ram_re_s, load_acc_s;
    logic [AW-1:0] ram_addr_s;

    tape_frame_ram #(
        .DEPTH  (TAPE_DEPTH),
        .ADDR_W (AW)
    ) u_ram (
        .clk   (CLOCK),
        .we    (ram_we_s & rst),
        .re    (ram_re_s),
        .addr  (ram_addr_s),
        .wdata (load_data),
        .rdata (ram_rdata_s)
    );

    // Next-state, head/length update and RAM port arbitration.
    always_comb begin
        dir_s      = decode_dir(PHOTO_TAPE_FWD, PHOTO_TAPE_REV);
        state_nxt  = state_r;
        dir_nxt    = dir_r;
        phase_nxt  = phase_r;
        head_nxt   = head_r;
        len_nxt    = len_r;
        ram_we_s   = 1'b0;
        ram_re_s   = 1'b0;
        ram_addr_s = head_r[AW-1:0];
        head_inc_s = head_r + LW'(1);
        head_dec_s = head_r - LW'(1);
        // load_ready_r is only ever set while idle with room left.
        load_acc_s = load_valid & load_ready_r & ~load_clear;
        case (state_r)
            RDR_IDLE: begin
                // Host actions own the RAM port this cycle; motion waits one cycle.
                if (load_clear) begin
                    len_nxt  = LW'(0);
                    head_nxt = LW'(0);
                end else if (load_acc_s) begin
                    ram_we_s   = 1'b1;
                    ram_addr_s = len_r[AW-1:0];
                    len_nxt    = len_r + LW'(1);
                    if (rewind) begin
                        head_nxt = LW'(0);
                    end else begin
                        head_nxt = head_r;
                    end
                end else if (rewind) begin
                    head_nxt = LW'(0);
                end else if ((dir_s == DIR_FWD) && (head_r < len_r)) begin
                    state_nxt  = RDR_HOLE;
                    dir_nxt    = DIR_FWD;
                    phase_nxt  = PW'(0);
                    ram_re_s   = 1'b1;
                    ram_addr_s = head_r[AW-1:0];
                end else if ((dir_s == DIR_REV) && (head_r != LW'(0))) begin
                    // Reverse backs the head onto the previous frame before reading it.
                    state_nxt  = RDR_HOLE;
                    dir_nxt    = DIR_REV;
                    phase_nxt  = PW'(0);
                    head_nxt   = head_dec_s;
                    ram_re_s   = 1'b1;
                    ram_addr_s = head_dec_s[AW-1:0];
                end else begin
                    state_nxt = RDR_IDLE;
                end
            end
            RDR_HOLE: begin
                phase_nxt = phase_r + PW'(1);
                if (phase_r == PW'(HOLE_CYCLES - 1)) begin
                    state_nxt = RDR_GAP;
                end else begin
                    state_nxt = RDR_HOLE;
                end
            end
            RDR_GAP: begin
                if (phase_r == PW'(FRAME_CYCLES - 1)) begin
                    // Frame boundary: the only point where the command is re-sampled.
                    phase_nxt = PW'(0);
                    if (dir_r == DIR_FWD) begin
                        head_nxt = head_inc_s;
                        if ((dir_s == DIR_FWD) && (head_inc_s < len_r)) begin
                            state_nxt  = RDR_HOLE;
                            ram_re_s   = 1'b1;
                            ram_addr_s = head_inc_s[AW-1:0];
                        end else begin
                            state_nxt = RDR_IDLE;
                            dir_nxt   = DIR_STOP;
                        end
                    end else begin
                        if ((dir_s == DIR_REV) && (head_r != LW'(0))) begin
                            state_nxt  = RDR_HOLE;
                            head_nxt   = head_dec_s;
                            ram_re_s   = 1'b1;
                            ram_addr_s = head_dec_s[AW-1:0];
                        end else begin
                            state_nxt = RDR_IDLE;
                            dir_nxt   = DIR_STOP;
                        end
                    end
                end else begin
                    phase_nxt = phase_r + PW'(1);
                end
            end
            default: begin
                state_nxt = RDR_IDLE;
                dir_nxt   = DIR_STOP;
                phase_nxt = PW'(0);
            end
        endcase
    end

    // State registers; status outputs are registered from next-state values.
    always_ff @(posedge CLOCK) begin
        if (!rst) begin
            state_r      <= RDR_IDLE;
            dir_r        <= DIR_STOP;
            phase_r      <= PW'(0);
            head_r       <= LW'(0);
            len_r        <= LW'(0);
            photo_r      <= 5'd0;
            load_ready_r <= 1'b0;
            at_end_r     <= 1'b1;
            at_start_r   <= 1'b1;
            moving_r     <= 1'b0;
        end else begin
            state_r      <= state_nxt;
            dir_r        <= dir_nxt;
            phase_r      <= phase_nxt;
            head_r       <= head_nxt;
            len_r        <= len_nxt;
            // RAM data lands the cycle after HOLE entry, so holes trail state by one.
            photo_r      <= (state_r == RDR_HOLE) ? ram_rdata_s : 5'd0;
            load_ready_r <= (state_nxt == RDR_IDLE) && (len_nxt < LW'(TAPE_DEPTH));
            at_end_r     <= (head_nxt == len_nxt);
            at_start_r   <= (head_nxt == LW'(0));
            moving_r     <= (state_nxt != RDR_IDLE);
        end
    end

    assign PHOTO1     = photo_r[0];
    assign PHOTO2     = photo_r[1];
    assign PHOTO3     = photo_r[2];
    assign PHOTO4     = photo_r[3];
    assign PHOTO5     = photo_r[4];
    assign load_ready = load_ready_r;
    assign tape_len   = len_r;
    assign head_pos   = head_r;
    assign at_end     = at_end_r;
    assign at_start   = at_start_r;
    assign moving     = moving_r;

endmodule

// File: tb/tb_phototape_reader_emu.sv
// Scoreboard bench for phototape_reader_emu with a small tape (4 frames),
// 10-cycle frame period and 4-cycle hole time. Stimulus pushes expected
// frames into a queue from an abstract tape/head model; a monitor frames the
// PHOTO stream independently and compares.
module tb_phototape_reader_emu;

    localparam int DEPTH = 4;
    localparam int FC    = 10;
    localparam int HC    = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          fwd, rev;
    logic          p1, p2, p3, p4, p5;
    logic          load_valid, load_ready, load_clear, rewind;
    logic [4:0]    load_data;
    logic [LW-1:0] tape_len, head_pos;
    logic          at_end, at_start, moving;
    logic [4:0]    photo_s;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_q [$];
    logic [4:0] model_tape [DEPTH];
    int         model_len  = 0;
    int         model_head = 0;

    int         mon_t      = 0;
    bit         mon_active = 1'b0;
    bit         mon_ok     = 1'b1;
    logic [4:0] mon_val    = 5'd0;

    always #5 clk = ~clk;

    assign photo_s = {p5, p4, p3, p2, p1};

    phototape_reader_emu #(
        .TAPE_DEPTH   (DEPTH),
        .FRAME_CYCLES (FC),
        .HOLE_CYCLES  (HC)
    ) dut (
        .CLOCK          (clk),
        .rst            (rst),
        .PHOTO_TAPE_FWD (fwd),
        .PHOTO_TAPE_REV (rev),
        .PHOTO1         (p1),
        .PHOTO2         (p2),
        .PHOTO3         (p3),
        .PHOTO4         (p4),
        .PHOTO5         (p5),
        .load_valid     (load_valid),
        .load_data      (load_data),
        .load_ready     (load_ready),
        .load_clear     (load_clear),
        .rewind         (rewind),
        .tape_len       (tape_len),
        .head_pos       (head_pos),
        .at_end         (at_end),
        .at_start       (at_start),
        .moving         (moving)
    );

    function automatic void check(string nm, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endfunction

    // Monitor: frames the PHOTO stream (hold for HC, blank to FC) and scores each frame.
    always @(negedge clk) begin
        if (!rst) begin
            mon_active = 1'b0;
            exp_q.delete();
        end else if (mon_active) begin
            mon_t++;
            if (mon_t == 1) begin
                mon_val = photo_s;
                mon_ok  = 1'b1;
            end else if (mon_t <= HC) begin
                if (photo_s != mon_val) mon_ok = 1'b0;
            end else begin
                if (photo_s != 5'd0) mon_ok = 1'b0;
            end
            if (mon_t < FC) begin
                if (!moving) mon_ok = 1'b0;
            end else begin
                check("frame_shape", int'(mon_ok), 1);
                if (exp_q.size() == 0) begin
                    check("frame_unexpected", int'(mon_val), -1);
                end else begin
                    check("frame_value", int'(mon_val), int'(exp_q.pop_front()));
                end
                if (moving) mon_t = 0;
                else mon_active = 1'b0;
            end
        end else begin
            check("idle_photo", int'(photo_s), 0);
            if (moving) begin
                mon_active = 1'b1;
                mon_t      = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(string tag);
        check({tag, "_tape_len"}, int'(tape_len), model_len);
        check({tag, "_head_pos"}, int'(head_pos), model_head);
        check({tag, "_at_end"},   int'(at_end),   int'(model_head == model_len));
        check({tag, "_at_start"}, int'(at_start), int'(model_head == 0));
    endtask

    task automatic do_load(logic [4:0] v, bit clr);
        tick();
        load_valid = 1'b1;
        load_data  = v;
        load_clear = clr;
        @(negedge clk);
        check("load_ready", int'(load_ready), int'(model_len < DEPTH));
        tick();
        load_valid = 1'b0;
        load_clear = 1'b0;
        if (clr) begin
            model_len  = 0;
            model_head = 0;
        end else if (model_len < DEPTH) begin
            model_tape[model_len] = v;
            model_len++;
        end
        @(negedge clk);
        check_status("load");
    endtask

    task automatic do_rewind();
        tick();
        rewind = 1'b1;
        tick();
        rewind = 1'b0;
        model_head = 0;
        @(negedge clk);
        check_status("rewind");
    endtask

    // Holds the drive pair for 'hold' clock edges; the command is seen at
    // each frame boundary, so hold edges allow (hold-1)/FC+1 frames.
    task automatic do_move(bit f, bit r, int hold, bit poke);
        int avail, frames, guard;
        if (f && !r)      avail = model_len - model_head;
        else if (r && !f) avail = model_head;
        else              avail = 0;
        frames = (hold - 1) / FC + 1;
        if (frames > avail) frames = avail;
        for (int j = 0; j < frames; j++) begin
            if (f) exp_q.push_back(model_tape[model_head + j]);
            else   exp_q.push_back(model_tape[model_head - 1 - j]);
        end
        if (f) model_head = model_head + frames;
        else   model_head = model_head - frames;
        tick();
        fwd = f;
        rev = r;
        for (int i = 0; i < hold; i++) begin
            if (poke && frames > 0 && i == 1) begin
                load_valid = 1'b1;
                load_data  = 5'h11;
                @(negedge clk);
                check("load_ready_moving", int'(load_ready), 0);
            end
            @(posedge clk);
            #1;
            load_valid = 1'b0;
        end
        fwd = 1'b0;
        rev = 1'b0;
        guard = 0;
        @(negedge clk);
        while (moving && guard < 8 * FC) begin
            @(negedge clk);
            guard++;
        end
        check("move_done", int'(moving), 0);
        @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        check_status("move");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b0;
        fwd        = 1'b0;
        rev        = 1'b0;
        load_valid = 1'b0;
        load_data  = 5'd0;
        load_clear = 1'b0;
        rewind     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_photo", int'(photo_s), 0);
        check("rst_load_ready", int'(load_ready), 0);
        check("rst_moving", int'(moving), 0);
        check_status("rst");
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("post_rst_load_ready", int'(load_ready), 1);

        // Directed: load, forward, reverse, mid-frame stop, both drives.
        do_load(5'h01, 1'b0);
        do_load(5'h1F, 1'b0);
        do_load(5'h0A, 1'b0);
        do_move(1'b1, 1'b0, 40, 1'b0);
        do_move(1'b0, 1'b1, 40, 1'b0);
        do_move(1'b1, 1'b0, 3, 1'b0);
        do_move(1'b1, 1'b1, 20, 1'b0);
        // Load while moving is dropped.
        do_move(1'b1, 1'b0, 15, 1'b1);
        // Capacity boundary: 4th accepted, 5th dropped.
        do_load(5'h15, 1'b0);
        do_load(5'h1B, 1'b0);
        do_move(1'b1, 1'b0, 5, 1'b0);
        // Run-off at the end stays idle.
        do_move(1'b1, 1'b0, 12, 1'b0);
        do_rewind();
        do_move(1'b0, 1'b1, 12, 1'b0);
        // Clear outranks a simultaneous load.
        do_load(5'h03, 1'b1);

        // Reset in the middle of a HOLE phase.
        do_load(5'h07, 1'b0);
        do_load(5'h09, 1'b0);
        tick();
        fwd = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        fwd = 1'b0;
        tick();
        rst = 1'b1;
        model_len  = 0;
        model_head = 0;
        @(negedge clk);
        check("midrst_photo", int'(photo_s), 0);
        check("midrst_load_ready0", int'(load_ready), 0);
        tick();
        @(negedge clk);
        check("midrst_photo_next", int'(photo_s), 0);
        check("midrst_load_ready1", int'(load_ready), 1);
        check("midrst_moving", int'(moving), 0);
        check_status("midrst");

        // Randomized operation mix against the tape/head model.
        for (int it = 0; it < 150; it++) begin
            int act;
            act = int'($urandom_range(0, 9));
            if (act <= 3) begin
                do_load(5'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0));
            end else if (act == 4) begin
                do_rewind();
            end else begin
                int d;
                d = int'($urandom_range(0, 5));
                do_move((d <= 2) || (d == 5), (d == 3) || (d == 4) || (d == 5),
                        int'($urandom_range(1, 45)), $urandom_range(0, 3) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phototape_reader_emu.md
Name: phototape_reader_emu

Overview:
- Emulates the G-15 built-in photoelectric tape reader directly upstream of io_top.
- Holds a host-loaded tape image of 5-bit frames.
- Moves the image under a virtual read head on io_top's PHOTO_TAPE_FWD/PHOTO_TAPE_REV commands.
- Presents each frame on PHOTO1..PHOTO5 with reader-like timing: frame on-time, then inter-frame gap.

Parameters:
- TAPE_DEPTH, 4096: frame capacity of the tape image (power of two).
- FRAME_CYCLES, 2000: CLOCK cycles per frame period, ≥ 4.
- HOLE_CYCLES, 800: cycles the holes are presented within a frame period, 1 ≤ HOLE_CYCLES < FRAME_CYCLES.

Ports:
- CLOCK  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- PHOTO_TAPE_FWD  in  1  forward drive from io_top.
- PHOTO_TAPE_REV  in  1  reverse drive from io_top.
- PHOTO1..PHOTO5  out  1 each  hole sense to io_top; PHOTO1 = frame bit 0.
- load_valid  in  1  host frame write strobe.
- load_data  in  5  host frame.
- load_ready  out  1  loader accepts this cycle.
- load_clear  in  1  empties the image, length := 0, head := 0.
- rewind  in  1  head := 0 (ignored while moving).
- tape_len  out  $clog2(TAPE_DEPTH)+1  frames loaded.
- head_pos  out  $clog2(TAPE_DEPTH)+1  current head frame index.
- at_end  out  1  head_pos == tape_len.
- at_start  out  1  head_pos == 0.
- moving  out  1  state ≠ IDLE.

Behaviour:
- Reset (rst = 0 at a CLOCK edge):
  - state IDLE; PHOTO1..5 = 0.
  - tape_len = 0, head_pos = 0.
  - load_ready = 0 for the reset cycle, then 1.
  - at_start = 1, at_end = 1, moving = 0.
  - Image contents are not cleared.
- Direction decode:
  - dir = FWD when FWD & ~REV; dir = REV when REV & ~FWD.
  - Both high, or both low, means stop.
- States: IDLE, HOLE, GAP.
- IDLE → HOLE when dir = FWD and head_pos < tape_len, or dir = REV and head_pos > 0.
  - Entering HOLE under REV first decrements head_pos.
  - The frame at head_pos is fetched; synchronous RAM read gives 1-cycle latency.
  - PHOTOx are driven from the cycle after entry.
  - The phase counter loads 0 on entry.
- HOLE: PHOTOx = frame bits, registered outputs.
  - After HOLE_CYCLES cycles → GAP; PHOTOx = 0.
- GAP: at phase count FRAME_CYCLES-1:
  - FWD: head_pos += 1.
  - If the command persists and another frame is available in that direction → HOLE, else → IDLE.
- Stop mid-frame (dir becomes stop, or reverses):
  - The current frame period completes; the FWD advance is applied.
  - Then → IDLE; direction changes take effect only at frame boundaries.
- Run-off boundaries:
  - FWD at head_pos == tape_len and REV at head_pos == 0 stay IDLE with PHOTOx = 0 (blank leader).
  - No wrap-around in either direction.
- Loader:
  - load_ready = (state == IDLE) & (tape_len < TAPE_DEPTH).
  - On load_valid & load_ready: write load_data at address tape_len; tape_len += 1 the next cycle.
  - load_valid while not ready is dropped.
- Other host controls:
  - load_clear takes priority over load_valid in the same cycle; honoured only in IDLE.
  - rewind is honoured only in IDLE; load_clear outranks rewind.
- Reset mid-operation: immediate return to reset values; tape_len = 0, so the image is logically discarded.
- Counter width: ceil(log2(FRAME_CYCLES)) bits.
- All outputs are registered; no combinational path from inputs to PHOTOx.

Decomposition:
- Shared package g15_io_pkg:
  - typedef photo_frame_t (logic [4:0]).
  - enum reader_state_t {RDR_IDLE, RDR_HOLE, RDR_GAP}.
  - enum tape_dir_t {DIR_STOP, DIR_FWD, DIR_REV}.
- One sub-module: tape_frame_ram.
  - Single-port, TAPE_DEPTH × 5 bits.
  - Synchronous write, synchronous read, 1-cycle read latency.
  - Port arbitration inside the emulator: writes only in IDLE, reads only on HOLE entry.

Test Plan:
- Load + forward read (FRAME_CYCLES = 10, HOLE_CYCLES = 4):
  - Load 5'h01, 5'h1F, 5'h0A; tape_len = 3.
  - Hold FWD: PHOTO = 01, 1F, 0A, each for 4 cycles followed by 6 zero cycles.
  - Then IDLE with head_pos = 3 and at_end = 1.
- Reverse: from head_pos = 3, hold REV → PHOTO = 0A, 1F, 01; head_pos = 0; at_start = 1.
- Mid-frame stop: drop FWD 2 cycles into HOLE of frame 0.
  - Frame completes the full 10-cycle period; head_pos = 1; IDLE.
  - PHOTO stays 0 afterward.
- Simultaneous FWD & REV from IDLE → no movement; moving = 0; PHOTO = 0.
- Loader boundaries:
  - TAPE_DEPTH = 4: the 5th load is dropped; load_ready = 0 at tape_len = 4.
  - load_valid while moving → dropped, tape_len unchanged.
  - load_clear + load_valid in the same cycle → tape_len = 0.
- Reset mid-HOLE: rst = 0 for 1 cycle.
  - Next cycle: PHOTO = 0, tape_len = 0, head_pos = 0, load_ready = 1.
